// File: rtl/multi_cycle_control_unit_if.sv
// multi_cycle_control_unit_if: opcode/flag inputs and datapath control outputs of the control unit
interface multi_cycle_control_unit_if;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic       ExtSel;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  modport master (
    output opcode, zero, sign,
    input  state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
           DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp
  );
  modport slave (
    input  opcode, zero, sign,
    output state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
           DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp
  );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EXE/MEM/WB sequencer with opcode decode and datapath strobes
module multi_cycle_control_unit (
  input logic                         CLK,
  input logic                         Reset,
  multi_cycle_control_unit_if.slave   bus
);
  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;
  logic [2:0] state_q, state_d;
  logic [5:0] op;
  logic i_add, i_sub, i_addi, i_or, i_and, i_ori, i_sll, i_slt, i_slti;
  logic i_sw, i_lw, i_beq, i_bne, i_bltz, i_j, i_jr, i_jal, i_halt;
  logic is_nop, is_br, is_jmp, is_ls, taken;
  assign op     = bus.opcode;
  assign i_add  = op == 6'b000000;
  assign i_sub  = op == 6'b000001;
  assign i_addi = op == 6'b000010;
  assign i_or   = op == 6'b010000;
  assign i_and  = op == 6'b010001;
  assign i_ori  = op == 6'b010010;
  assign i_sll  = op == 6'b011000;
  assign i_slt  = op == 6'b100110;
  assign i_slti = op == 6'b100111;
  assign i_sw   = op == 6'b110000;
  assign i_lw   = op == 6'b110001;
  assign i_beq  = op == 6'b110100;
  assign i_bne  = op == 6'b110101;
  assign i_bltz = op == 6'b110110;
  assign i_j    = op == 6'b111000;
  assign i_jr   = op == 6'b111001;
  assign i_jal  = op == 6'b111010;
  assign i_halt = op == 6'b111111;
  assign is_br  = i_beq | i_bne | i_bltz;
  assign is_jmp = i_j | i_jr | i_jal;
  assign is_ls  = i_sw | i_lw;
  assign is_nop = ~(i_add | i_sub | i_addi | i_or | i_and | i_ori | i_sll | i_slt | i_slti |
                    is_ls | is_br | is_jmp | i_halt);
  assign taken  = (i_beq & bus.zero) | (i_bne & ~bus.zero) | (i_bltz & bus.sign);
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID:     state_d = (is_jmp | is_nop) ? S_IF : i_halt ? S_ID : is_br ? S_EXE_BR :
                          is_ls ? S_EXE_LS : S_EXE_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = i_lw ? S_WB_LD : S_IF;
      S_EXE_AL: state_d = S_WB_AL;
      default:  state_d = S_IF;
    endcase
  end
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  // Strobes are gated by Reset so an in-flight write is dropped the moment reset asserts
  always_comb begin
    bus.state     = state_q;
    bus.IRWre     = Reset & (state_q == S_IF);
    bus.InsMemRW  = Reset & (state_q == S_IF);
    bus.PCWre     = Reset & ((state_q == S_ID & (is_jmp | is_nop)) | state_q == S_EXE_BR |
                             (state_q == S_MEM & i_sw) | state_q == S_WB_AL | state_q == S_WB_LD);
    bus.RegWre    = Reset & (state_q == S_WB_AL | state_q == S_WB_LD | (state_q == S_ID & i_jal));
    bus.mRD       = Reset & (state_q == S_MEM) & i_lw;
    bus.mWR       = Reset & (state_q == S_MEM) & i_sw;
    bus.ALUSrcA   = i_sll;
    bus.ALUSrcB   = i_addi | i_ori | i_slti | is_ls;
    bus.DBDataSrc = i_lw;
    bus.WrRegDSrc = ~i_jal;
    bus.ExtSel    = ~i_ori;
    bus.RegDst    = i_jal ? 2'b00 : (i_addi | i_ori | i_slti | i_lw) ? 2'b01 : 2'b10;
    bus.ALUOp     = (i_sub | is_br) ? 3'b001 : i_sll ? 3'b010 : (i_or | i_ori) ? 3'b011 :
                    i_and ? 3'b100 : (i_slt | i_slti) ? 3'b110 : 3'b000;
    bus.PCSrc     = (i_j | i_jal) ? 2'b11 : i_jr ? 2'b10 : taken ? 2'b01 : 2'b00;
  end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: scoreboard of per-cycle expected state/strobes checked on the falling edge
module tb_multi_cycle_control_unit;
  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, imr, rw, rd, wr;
    logic [1:0] pcs, rdst;
    logic [2:0] aop;
    logic       sa, sb, dbs, wrs, ext;
  } exp_t;
  logic CLK = 1'b1;
  logic Reset = 1'b0;
  multi_cycle_control_unit_if bus ();
  multi_cycle_control_unit dut (.CLK(CLK), .Reset(Reset), .bus(bus));
  always #5 CLK = ~CLK;
  exp_t exp_q[$];
  exp_t e_m;
  int n_chk = 0;
  int n_pass = 0;
  string cur = "rst";
  logic [1:0] s_rdst;
  logic [2:0] s_aop;
  logic s_sa, s_sb, s_dbs, s_wrs, s_ext;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  task automatic steer(input logic [1:0] rdst, input logic [2:0] aop,
                       input logic sa, sb, dbs, wrs, ext);
    s_rdst = rdst; s_aop = aop; s_sa = sa; s_sb = sb; s_dbs = dbs; s_wrs = wrs; s_ext = ext;
  endtask
  task automatic push(input logic [2:0] st, input logic pcw, rw, rd, wr, input logic [1:0] pcs);
    exp_t e;
    e = '{st: st, pcw: pcw, irw: st == 3'b000, imr: st == 3'b000, rw: rw, rd: rd, wr: wr,
          pcs: pcs, rdst: s_rdst, aop: s_aop, sa: s_sa, sb: s_sb, dbs: s_dbs, wrs: s_wrs,
          ext: s_ext};
    exp_q.push_back(e);
  endtask
  task automatic go(input string nm, input logic [5:0] op, input logic z, s);
    int n;
    cur = nm; bus.opcode = op; bus.zero = z; bus.sign = s;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge CLK); #1; n++;
    end
    chk({nm, ".drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic step();
    @(posedge CLK); #2;
  endtask
  always @(negedge CLK)
    if (exp_q.size() != 0) begin
      e_m = exp_q.pop_front();
      chk({cur, ".state"}, bus.state, e_m.st);
      chk({cur, ".PCWre"}, bus.PCWre, e_m.pcw);
      chk({cur, ".IRWre"}, bus.IRWre, e_m.irw);
      chk({cur, ".InsMemRW"}, bus.InsMemRW, e_m.imr);
      chk({cur, ".RegWre"}, bus.RegWre, e_m.rw);
      chk({cur, ".mRD"}, bus.mRD, e_m.rd);
      chk({cur, ".mWR"}, bus.mWR, e_m.wr);
      chk({cur, ".PCSrc"}, bus.PCSrc, e_m.pcs);
      chk({cur, ".RegDst"}, bus.RegDst, e_m.rdst);
      chk({cur, ".ALUOp"}, bus.ALUOp, e_m.aop);
      chk({cur, ".ALUSrcA"}, bus.ALUSrcA, e_m.sa);
      chk({cur, ".ALUSrcB"}, bus.ALUSrcB, e_m.sb);
      chk({cur, ".DBDataSrc"}, bus.DBDataSrc, e_m.dbs);
      chk({cur, ".WrRegDSrc"}, bus.WrRegDSrc, e_m.wrs);
      chk({cur, ".ExtSel"}, bus.ExtSel, e_m.ext);
    end
  initial begin
    bus.opcode = 6'b000000; bus.zero = 1'b0; bus.sign = 1'b0;
    #28;
    chk("rst.state", bus.state, 3'b000);
    chk("rst.IRWre", bus.IRWre, 1'b0);
    chk("rst.InsMemRW", bus.InsMemRW, 1'b0);
    chk("rst.PCWre", bus.PCWre, 1'b0);
    #4 Reset = 1'b1;
    steer(2'b10, 3'b000, 0, 0, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b110, 0, 0, 0, 0, 2'b00); push(3'b111, 1, 1, 0, 0, 2'b00);
    go("add", 6'b000000, 0, 0); step();
    steer(2'b01, 3'b000, 0, 1, 1, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b010, 0, 0, 0, 0, 2'b00); push(3'b011, 0, 0, 1, 0, 2'b00);
    push(3'b100, 1, 1, 0, 0, 2'b00);
    go("lw", 6'b110001, 0, 0); step();
    steer(2'b10, 3'b000, 0, 1, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b010, 0, 0, 0, 0, 2'b00); push(3'b011, 1, 0, 0, 1, 2'b00);
    push(3'b000, 0, 0, 0, 0, 2'b00);
    go("sw", 6'b110000, 0, 0);
    steer(2'b10, 3'b001, 0, 0, 0, 1, 1);
    push(3'b001, 0, 0, 0, 0, 2'b01); push(3'b101, 1, 0, 0, 0, 2'b01);
    go("beq_t", 6'b110100, 1, 0); step();
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b101, 1, 0, 0, 0, 2'b00);
    go("beq_nt", 6'b110100, 0, 0); step();
    push(3'b000, 0, 0, 0, 0, 2'b01); push(3'b001, 0, 0, 0, 0, 2'b01);
    push(3'b101, 1, 0, 0, 0, 2'b01);
    go("bne_t", 6'b110101, 0, 0); step();
    push(3'b000, 0, 0, 0, 0, 2'b01); push(3'b001, 0, 0, 0, 0, 2'b01);
    push(3'b101, 1, 0, 0, 0, 2'b01);
    go("bltz_t", 6'b110110, 0, 1); step();
    steer(2'b00, 3'b000, 0, 0, 0, 0, 1);
    push(3'b000, 0, 0, 0, 0, 2'b11); push(3'b001, 1, 1, 0, 0, 2'b11);
    go("jal", 6'b111010, 0, 0); step();
    steer(2'b10, 3'b000, 0, 0, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b11); push(3'b001, 1, 0, 0, 0, 2'b11);
    go("j", 6'b111000, 0, 0); step();
    push(3'b000, 0, 0, 0, 0, 2'b10); push(3'b001, 1, 0, 0, 0, 2'b10);
    go("jr", 6'b111001, 0, 0); step();
    steer(2'b01, 3'b011, 0, 1, 0, 1, 0);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b110, 0, 0, 0, 0, 2'b00); push(3'b111, 1, 1, 0, 0, 2'b00);
    go("ori", 6'b010010, 0, 0); step();
    steer(2'b10, 3'b010, 1, 0, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b110, 0, 0, 0, 0, 2'b00); push(3'b111, 1, 1, 0, 0, 2'b00);
    go("sll", 6'b011000, 0, 0); step();
    steer(2'b01, 3'b110, 0, 1, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b110, 0, 0, 0, 0, 2'b00); push(3'b111, 1, 1, 0, 0, 2'b00);
    go("slti", 6'b100111, 0, 0); step();
    steer(2'b10, 3'b100, 0, 0, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b110, 0, 0, 0, 0, 2'b00); push(3'b111, 1, 1, 0, 0, 2'b00);
    go("and", 6'b010001, 0, 0); step();
    steer(2'b10, 3'b000, 0, 0, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 1, 0, 0, 0, 2'b00);
    go("nop", 6'b101010, 0, 0); step();
    push(3'b000, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 12; i++) push(3'b001, 0, 0, 0, 0, 2'b00);
    go("halt", 6'b111111, 0, 0);
    Reset = 1'b0; #1;
    chk("halt_rst.state", bus.state, 3'b000);
    chk("halt_rst.IRWre", bus.IRWre, 1'b0);
    step(); Reset = 1'b1;
    steer(2'b10, 3'b000, 0, 1, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b010, 0, 0, 0, 0, 2'b00);
    go("sw_abort", 6'b110000, 0, 0); step();
    chk("sw_abort.mem_state", bus.state, 3'b011);
    chk("sw_abort.mem_mWR", bus.mWR, 1'b1);
    Reset = 1'b0; #1;
    chk("sw_abort.mWR", bus.mWR, 1'b0);
    chk("sw_abort.state", bus.state, 3'b000);
    chk("sw_abort.PCWre", bus.PCWre, 1'b0);
    chk("sw_abort.InsMemRW", bus.InsMemRW, 1'b0);
    step();
    chk("sw_abort.hold", bus.state, 3'b000);
    Reset = 1'b1;
    steer(2'b10, 3'b001, 0, 0, 0, 1, 1);
    push(3'b000, 0, 0, 0, 0, 2'b00); push(3'b001, 0, 0, 0, 0, 2'b00);
    push(3'b110, 0, 0, 0, 0, 2'b00); push(3'b111, 1, 1, 0, 0, 2'b00);
    go("sub_resume", 6'b000001, 0, 0); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
